// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Load/store alignment between the execute stage and the data
//               memory port. Stores become word-aligned requests with byte
//               enables and a lane-replicated write word. Loads are
//               lane-selected and then sign- or zero-extended.
//               Optional macro LSU_TIMEOUT_EN adds a mem_ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Only a 32-bit datapath is implemented; the timeout must be at least one.
  generate
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("lsu_align: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic            r_store;

  logic            w_f3_legal;
  logic            w_misaligned;
  logic            w_fault;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_lane;
  logic [31:0]     w_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
`endif

  // Request decode: legality, byte enables and replicated store data.
  always_comb begin
    w_f3_legal   = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: w_f3_legal = 1'b1;
      3'b001, 3'b101: w_f3_legal = 1'b1;
      3'b010:         w_f3_legal = 1'b1;
      default:        w_f3_legal = 1'b0;
    endcase
    // Signed and unsigned store widths do not exist.
    if (req_store && req_funct3[2]) w_f3_legal = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = req_addr[0];
        w_be         = 4'b0011 << req_addr[1:0];
        w_wdata      = {2{req_wdata[15:0]}};
      end
      default: begin
        w_misaligned = (req_addr[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = req_wdata;
      end
    endcase
    w_fault = !w_f3_legal || w_misaligned;
  end

  // Load return path: shift the addressed lane down, then extend.
  always_comb begin
    w_lane = mem_rdata >> {r_addr_lo, 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Handshake FSM; every output is a register so nothing glitches at the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_store   <= 1'b0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_store   <= req_store;
            req_ready <= 1'b0;
            if (w_fault) begin
              // Faulting requests never touch memory.
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state   <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= w_be;
              mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
              mem_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_store ? '0 : w_ext;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == C_TIMEOUT) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// ============================================================================
// Module      : tb_lsu_align
// Description : Directed self-checking bench for lsu_align. Timeout steps are
//               included only when LSU_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_align;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total;
  int bad;
  int req_cycles;
  int cyc;

  lsu_align #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle (cycle 0), then release it.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // Reset values.
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // mem_ack outside ACCESS must be ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ack_ready", {31'd0, req_ready}, 32'd1);

    // LB at 0x103, immediate ack.
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    chk("lb_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h0000_0100);
    chk("lb_mem_be", {28'd0, mem_be}, 32'h8);
    chk("lb_mem_we", {31'd0, mem_we}, 32'd0);
    chk("lb_ready_busy", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("lb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("lb_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("lb_ready_in_resp", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lb_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("lb_ready_back", {31'd0, req_ready}, 32'd1);

    // LHU at 0x202, ack after three wait cycles.
    issue(1'b0, 3'b101, 32'h0000_0202, 32'd0);
    req_cycles = 0;
    mem_rdata = 32'hBEEF_0001;
    for (int k = 1; k <= 4; k++) begin
      mem_ack = (k == 4);
      @(negedge clk);
      if (mem_req) req_cycles++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lhu_req_cycles", req_cycles, 32'd4);
    chk("lhu_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lhu_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
    chk("lhu_mem_req_drop", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // SB at 0x301.
    issue(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sb_mem_be", {28'd0, mem_be}, 32'h2);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_mem_addr", mem_addr, 32'h0000_0300);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sb_rsp_rdata", rsp_rdata, 32'd0);
    chk("sb_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;

    // Misaligned LW at 0x402: error in cycle 1, no memory request.
    issue(1'b0, 3'b010, 32'h0000_0402, 32'd0);
    @(negedge clk);
    chk("lw_mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lw_mis_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("lw_mis_rsp_rdata", rsp_rdata, 32'd0);
    chk("lw_mis_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // SH with funct3=101 is illegal.
    issue(1'b1, 3'b101, 32'h0000_0500, 32'h0000_1111);
    @(negedge clk);
    chk("sh101_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sh101_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("sh101_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of ACCESS.
    issue(1'b0, 3'b010, 32'h0000_0000, 32'd0);
    @(negedge clk);
    chk("rstacc_mem_req_up", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstacc_mem_req_async", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstacc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstacc_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h0000_0000, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstacc_lw_be", {28'd0, mem_be}, 32'hF);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("rstacc_lw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rstacc_lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rstacc_lw_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
    // LW with no ack: error response 17 cycles after mem_req rises.
    issue(1'b0, 3'b010, 32'h0000_0000, 32'd0);
    cyc = 1;
    @(negedge clk);
    chk("to_mem_req_up", {31'd0, mem_req}, 32'd1);
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", cyc - 1, 32'd17);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store data path between the core's execute stage and the data memory port.
- For stores, it turns a byte address and an RV32 funct3 width into a word-aligned request, with byte enables and a lane-replicated write word.
- For loads, it takes the raw 32-bit memory word and returns it lane-selected and then sign- or zero-extended. It is the data-side counterpart of the immediate sign extender.
- Memory handshake: req/ack, with a small FSM and one outstanding access.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before an error is returned; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  the core presents an access.
- req_ready  out  1  the block can accept an access; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, least-significant bytes used.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  DATA_WIDTH  word address, with bits [1:0] = 0.
- mem_wdata  out  DATA_WIDTH  write word, with the data replicated across lanes.
- mem_ack  in  1  memory accepted or completed the access; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  raw read word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and on error.
- rsp_err  out  1  misaligned access, illegal funct3, or timeout.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (asynchronous, while rst is high):
  - state goes to IDLE.
  - req_ready=1, and mem_req, mem_we, rsp_valid and rsp_err are 0.
  - mem_be, mem_addr, mem_wdata and rsp_rdata are 0.
  - Reset during ACCESS drops mem_req immediately, and no response is produced.
- IDLE:
  - The request is accepted when req_valid is high (req_ready is 1 here). addr, funct3, store and wdata are registered.
  - Legality check on the request:
    - misaligned if H/HU with addr[0]=1, or W with addr[1:0]!=0;
    - illegal if funct3 is not one of {000,001,010,100,101}, or is a store with funct3 100 or 101.
  - A legal request goes to ACCESS on the next cycle.
  - A faulting request goes straight to RESP with rsp_err=1 and no mem_req.
- ACCESS:
  - mem_req=1 and mem_addr={addr[31:2],2'b00}.
  - mem_we=req_store.
  - mem_be:
    - B: 4'b0001<<addr[1:0].
    - H: 4'b0011<<addr[1:0].
    - W: 4'b1111.
    - For loads, mem_be still reflects the width.
  - mem_wdata:
    - B: {4{wdata[7:0]}}.
    - H: {2{wdata[15:0]}}.
    - W: wdata.
  - All mem_* outputs stay stable until mem_ack.
  - On mem_ack the block moves to RESP and captures the load result:
    - the selected lane is mem_rdata>>(8*addr[1:0]);
    - B is sign-extended from bit 7, BU is zero-extended, H is sign-extended from bit 15, HU is zero-extended, W is passed through.
  - mem_req drops in the cycle after the ack.
- RESP:
  - rsp_valid=1 for exactly one cycle, with registered rsp_rdata and rsp_err. The next state is IDLE.
  - req_ready is 0 in this state, so there is no back-to-back acceptance.
- Latency:
  - A legal access with mem_ack in its first ACCESS cycle is accepted at cycle 0, has mem_req in cycle 1 and rsp_valid in cycle 2.
  - An error response is accepted at cycle 0 with rsp_valid in cycle 1.
- rsp_rdata is 0 for stores and errors.
- mem_ack while not in ACCESS is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops and the block goes to RESP with rsp_err=1 and rsp_rdata=0.
  - If mem_ack arrives in that same cycle, the ack wins.
- Undefined: there is no counter, and ACCESS waits indefinitely for mem_ack.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234, immediate ack:
  - mem_addr=0x100 and mem_be=4'b1000;
  - rsp_rdata=0xFFFF_FF80 in cycle 2, rsp_err=0.
- LHU at addr 0x202, mem_rdata=0xBEEF_0001, ack after 3 wait cycles:
  - rsp_rdata=0x0000_BEEF;
  - mem_req stays high for 4 cycles.
- SB at addr 0x301, wdata=0x1234_56A5:
  - mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5_A5A5;
  - rsp_rdata=0, rsp_err=0.
- LW at addr 0x402, and SH with funct3=101:
  - each gives rsp_err=1 in cycle 1;
  - mem_req is never asserted.
- rst pulsed during ACCESS:
  - mem_req goes to 0 asynchronously, with no rsp_valid;
  - req_ready=1 after release, and the next LW at 0x0 completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, LW with no ack:
  - rsp_err=1 with rsp_valid 17 cycles after mem_req first rises.
